serial_pair_tx: RTL and testbench
=================================

SERIAL_PAIR_TX -- requirements
Module: serial_pair_tx

Interface
REQ-001 The block SHALL have a parameter W, default 8, giving the word width in bits (legal range 2..32).
REQ-002 The block SHALL have a parameter GAP, default 2, giving the idle cycles after each frame (legal range 0..15).
REQ-003 The block SHALL have port CLOCK  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port IN_VALID  input  1  word pair offered for transmission.
REQ-006 The block SHALL have port IN_A  input  W  word serialised onto LINE1.
REQ-007 The block SHALL have port IN_B  input  W  word serialised onto LINE2.
REQ-008 The block SHALL have port IN_READY  output  1  block accepts a word pair this cycle.
REQ-009 The block SHALL have port LINE1  output  1  serial bit of IN_A, LSB first.
REQ-010 The block SHALL have port LINE2  output  1  serial bit of IN_B, LSB first.
REQ-011 The block SHALL have port FRAME  output  1  high while LINE1/LINE2 carry valid data bits.
REQ-012 The block SHALL have port DONE  output  1  one-cycle pulse coincident with the last data bit.

Function
REQ-013 The state machine SHALL have exactly three states: IDLE, SHIFT and GAPW.
REQ-014 In IDLE, IN_READY SHALL be 1; in SHIFT and GAPW, IN_READY SHALL be 0.
REQ-015 A transfer SHALL occur when IN_VALID=1 and IN_READY=1 at a rising edge; IN_A/IN_B SHALL be captured into two W-bit shift registers at that edge, the bit counter SHALL be cleared to 0, and the state SHALL become SHIFT.
REQ-016 IN_VALID, IN_A and IN_B SHALL be ignored while IN_READY=0; no offered word pair SHALL be partially captured or corrupted.
REQ-017 In SHIFT, LINE1/LINE2 SHALL equal bit 0 of the respective shift register, FRAME SHALL be 1, and both registers SHALL shift right by one with zero fill each cycle.
REQ-018 First-bit latency SHALL be exactly one cycle: bit 0 appears in the cycle after the transfer edge, and bit k appears k+1 cycles after that edge.
REQ-019 SHIFT SHALL last exactly W cycles; DONE SHALL be 1 only in the cycle the counter equals W-1.
REQ-020 After the last bit, the state SHALL become GAPW if GAP>0, otherwise IDLE.
REQ-021 GAPW SHALL last exactly GAP cycles with LINE1=LINE2=FRAME=0, then return to IDLE.
REQ-022 The frame period SHALL be W+GAP+1 cycles minimum, since IDLE always lasts at least one cycle.
REQ-023 In IDLE and GAPW, LINE1, LINE2, FRAME and DONE SHALL all be 0.
REQ-024 All outputs SHALL be driven from registers or the state decode only, with no combinational path from any input to any output.
REQ-025 The bit counter SHALL be ceil(log2(W)) bits wide and SHALL never wrap within a frame.

Reset
REQ-026 While RESET=1, the state SHALL be IDLE, the shift registers and counters SHALL be 0, IN_READY=1, and LINE1=LINE2=FRAME=DONE=0, independent of CLOCK.
REQ-027 Assertion of RESET during SHIFT or GAPW SHALL abort the frame immediately; no DONE SHALL be produced for the aborted word.
REQ-028 After RESET deasserts, the first rising edge SHALL be able to accept a transfer.

Structure
REQ-029 The state encoding (IDLE, SHIFT, GAPW) and the default W and GAP constants SHALL reside in the shared package serial_pkg.
REQ-030 The dual W-bit shift register SHALL be a single sub-module, serial_pair_shreg, with load, shift, and two bit-0 outputs; the FSM and counters SHALL remain in serial_pair_tx.

Verification (W=8, GAP=2)
REQ-031 Single word: IN_A=8'hB5 and IN_B=8'h0F with handshake at cycle 0 -> LINE1 = 1,0,1,0,1,1,0,1 and LINE2 = 1,1,1,1,0,0,0,0 over cycles 1-8, FRAME=1 in cycles 1-8, and DONE=1 only in cycle 8.
REQ-032 Back-to-back: IN_VALID held at 1 with two words -> second handshake at cycle 11, second frame bits in cycles 12-19, and LINE1=LINE2=FRAME=0 in cycles 9-11.
REQ-033 Busy ignore: IN_A changed to 8'hFF during cycles 2-10 -> the first frame is unchanged and IN_READY=0 in cycles 1-10.
REQ-034 Mid-frame reset: RESET asserted in cycle 4 -> all outputs are 0 and IN_READY=1 within the same cycle (asynchronous), with no DONE; a new word accepted after release transmits correctly.
REQ-035 GAP=0 build: a second handshake occurs at cycle 9 and its first bit appears in cycle 10.
REQ-036 Boundary widths: with W=2 and W=32, random pairs scoreboarded bit-exact against the LSB-first serialisation of IN_A/IN_B -> zero mismatches.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM encoding and default geometry for the serial pair transmitter
package serial_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAPW} state_t;
  localparam int W_DEF = 8;
  localparam int GAP_DEF = 2;
endpackage

// File: rtl/serial_pair_tx_if.sv
// serial_pair_tx_if: word-pair handshake plus serial line outputs
interface serial_pair_tx_if import serial_pkg::*; #(parameter int W = W_DEF);
  logic         IN_VALID;
  logic [W-1:0] IN_A;
  logic [W-1:0] IN_B;
  logic         IN_READY;
  logic         LINE1;
  logic         LINE2;
  logic         FRAME;
  logic         DONE;
  modport master (output IN_VALID, IN_A, IN_B, input IN_READY, LINE1, LINE2, FRAME, DONE);
  modport slave  (input IN_VALID, IN_A, IN_B, output IN_READY, LINE1, LINE2, FRAME, DONE);
endinterface

// File: rtl/serial_pair_shreg.sv
// serial_pair_shreg: two W-bit right-shifting registers with parallel load, bit 0 exposed
module serial_pair_shreg import serial_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         a0_o,
  output logic         b0_o
);
  logic [W-1:0] a_q, b_q, a_d, b_d;
  // load wins over shift; shifting fills with zeros from the top
  always_comb begin
    a_d = load_i ? a_i : shift_i ? a_q >> 1 : a_q;
    b_d = load_i ? b_i : shift_i ? b_q >> 1 : b_q;
  end
  // register update with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end
  assign a0_o = a_q[0];
  assign b0_o = b_q[0];
endmodule

// File: rtl/serial_pair_tx.sv
// serial_pair_tx: serialises a word pair LSB first onto two lines with a frame strobe and idle gap
module serial_pair_tx import serial_pkg::*; #(
  parameter int W   = W_DEF,
  parameter int GAP = GAP_DEF
) (
  input logic             CLOCK,
  input logic             RESET,
  serial_pair_tx_if.slave bus
);
  localparam int CW = $clog2(W);
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    gap_q;
  logic          a0, b0, load, shift, last;
  assign load  = bus.IN_VALID && (state_q == IDLE);
  assign shift = (state_q == SHIFT);
  assign last  = (cnt_q == CW'(W - 1));
  serial_pair_shreg #(.W(W)) u_shreg (
    .clk    (CLOCK),
    .rst    (RESET),
    .load_i (load),
    .shift_i(shift),
    .a_i    (bus.IN_A),
    .b_i    (bus.IN_B),
    .a0_o   (a0),
    .b0_o   (b0)
  );
  // frame sequencing: accept in IDLE, W data cycles, then GAP idle cycles
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.IN_VALID) begin
          state_q <= SHIFT;
          cnt_q   <= '0;
        end
        SHIFT: if (last) begin
          state_q <= (GAP > 0) ? GAPW : IDLE;
          gap_q   <= '0;
        end else cnt_q <= cnt_q + 1'b1;
        GAPW: if (int'(gap_q) == GAP - 1) state_q <= IDLE;
          else gap_q <= gap_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.IN_READY = (state_q == IDLE);
  assign bus.FRAME    = shift;
  assign bus.LINE1    = shift & a0;
  assign bus.LINE2    = shift & b0;
  assign bus.DONE     = shift & last;
endmodule

// File: tb/tb_serial_pair_tx.sv
// tb_serial_pair_tx: vector table, corner sequences and randomized reference-model checks
module tb_serial_pair_tx;
  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 CLOCK = ~CLOCK;

  serial_pair_tx_if #(.W(8))  if8  ();
  serial_pair_tx_if #(.W(8))  if0  ();
  serial_pair_tx_if #(.W(2))  if2  ();
  serial_pair_tx_if #(.W(32)) if32 ();

  serial_pair_tx #(.W(8),  .GAP(2)) dut8  (.CLOCK(CLOCK), .RESET(RESET), .bus(if8));
  serial_pair_tx #(.W(8),  .GAP(0)) dut0  (.CLOCK(CLOCK), .RESET(RESET), .bus(if0));
  serial_pair_tx #(.W(2),  .GAP(1)) dut2  (.CLOCK(CLOCK), .RESET(RESET), .bus(if2));
  serial_pair_tx #(.W(32), .GAP(3)) dut32 (.CLOCK(CLOCK), .RESET(RESET), .bus(if32));

  typedef struct {
    logic       v;
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] exp;
  } vec_t;

  vec_t tv[24];

  task automatic drive(input int id, input logic v, input logic [31:0] a, input logic [31:0] b);
    case (id)
      8: begin if8.IN_VALID = v; if8.IN_A = a[7:0]; if8.IN_B = b[7:0]; end
      0: begin if0.IN_VALID = v; if0.IN_A = a[7:0]; if0.IN_B = b[7:0]; end
      2: begin if2.IN_VALID = v; if2.IN_A = a[1:0]; if2.IN_B = b[1:0]; end
      default: begin if32.IN_VALID = v; if32.IN_A = a; if32.IN_B = b; end
    endcase
  endtask

  // {ready, frame, done, line1, line2}
  function automatic logic [4:0] outs(input int id);
    case (id)
      8:       return {if8.IN_READY, if8.FRAME, if8.DONE, if8.LINE1, if8.LINE2};
      0:       return {if0.IN_READY, if0.FRAME, if0.DONE, if0.LINE1, if0.LINE2};
      2:       return {if2.IN_READY, if2.FRAME, if2.DONE, if2.LINE1, if2.LINE2};
      default: return {if32.IN_READY, if32.FRAME, if32.DONE, if32.LINE1, if32.LINE2};
    endcase
  endfunction

  task automatic chk(input string nm, input int c, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d rdy/frm/done/l1/l2 got %b expected %b", nm, c, act, exp);
    end
  endtask

  task automatic run_rand(input int id, input int w, input int gap, input int n);
    logic [31:0] mask, ca, cb, ra, rb;
    logic        v, in_f;
    int          s, nf, k;
    logic [4:0]  e;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(posedge CLOCK); #1 drive(id, 1'b0, '0, '0);
    end
    s = -1000;
    nf = 0;
    ca = '0;
    cb = '0;
    for (int c = 0; c < n; c++) begin
      v  = ($urandom_range(0, 2) != 0);
      ra = $urandom & mask;
      rb = $urandom & mask;
      @(posedge CLOCK); #1 drive(id, v, ra, rb);
      in_f = (c > s) && (c <= s + w);
      k = in_f ? c - s - 1 : 0;
      e = {c >= nf, in_f, in_f && (c == s + w), in_f & ca[k], in_f & cb[k]};
      @(negedge CLOCK) chk($sformatf("rand_w%0d", w), c, outs(id), e);
      if (v && c >= nf) begin
        s = c;
        ca = ra;
        cb = rb;
        nf = c + w + gap + 1;
      end
    end
    @(posedge CLOCK); #1 drive(id, 1'b0, '0, '0);
  endtask

  initial begin
    logic [7:0] wa, wb, pa;
    logic       f1, f2;
    int         k;
    drive(8, 0, '0, '0);
    drive(0, 0, '0, '0);
    drive(2, 0, '0, '0);
    drive(32, 0, '0, '0);
    for (int n = 0; n < 24; n++) begin
      tv[n].v = (n <= 11);
      tv[n].a = (n == 0 || n == 1) ? 8'hB5 : (n <= 10) ? 8'hFF : (n == 11) ? 8'h3C : 8'($urandom);
      tv[n].b = (n == 0) ? 8'h0F : (n <= 10) ? 8'h5A : (n == 11) ? 8'hA6 : 8'($urandom);
      f1 = (n >= 1 && n <= 8);
      f2 = (n >= 12 && n <= 19);
      wa = f1 ? 8'hB5 : 8'h3C;
      wb = f1 ? 8'h0F : 8'hA6;
      k  = f1 ? n - 1 : f2 ? n - 12 : 0;
      tv[n].exp = {n == 0 || n == 11 || n >= 22, f1 | f2, n == 8 || n == 19,
                   (f1 | f2) & wa[k], (f1 | f2) & wb[k]};
    end

    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    chk("reset_w8", 0, outs(8), 5'b10000);
    chk("reset_gap0", 0, outs(0), 5'b10000);
    chk("reset_w2", 0, outs(2), 5'b10000);
    chk("reset_w32", 0, outs(32), 5'b10000);
    @(posedge CLOCK); #1 RESET = 1'b0;

    for (int n = 0; n < 24; n++) begin
      @(posedge CLOCK); #1 drive(8, tv[n].v, 32'(tv[n].a), 32'(tv[n].b));
      @(negedge CLOCK) chk("table", n, outs(8), tv[n].exp);
    end

    @(posedge CLOCK); #1 drive(8, 1'b1, 32'hB5, 32'h0F);
    for (int c = 1; c <= 4; c++) begin
      @(posedge CLOCK); #1 drive(8, 1'b0, 32'hFF, 32'hFF);
    end
    chk("pre_reset_frame", 4, {outs(8)[4:3], 3'b000}, 5'b01000);
    RESET = 1'b1;
    #1 chk("async_reset", 4, outs(8), 5'b10000);
    @(posedge CLOCK); #1 chk("reset_held", 5, outs(8), 5'b10000);
    RESET = 1'b0;
    drive(8, 1'b1, 32'h96, 32'h69);
    for (int c = 1; c <= 11; c++) begin
      @(posedge CLOCK); #1 drive(8, 1'b0, '0, '0);
      pa = 8'h96 >> (c - 1);
      wb = 8'h69 >> (c - 1);
      @(negedge CLOCK) chk("post_reset", c, outs(8),
                           {c >= 11, c <= 8, c == 8, (c <= 8) & pa[0], (c <= 8) & wb[0]});
    end

    for (int c = 0; c <= 10; c++) begin
      @(posedge CLOCK); #1 drive(0, c <= 9, (c == 0) ? 32'hB5 : 32'h3D, (c == 0) ? 32'h0F : 32'hF0);
      f1 = (c >= 1 && c <= 8);
      pa = 8'hB5 >> (c - 1);
      wb = 8'h0F >> (c - 1);
      @(negedge CLOCK) chk("gap0", c, outs(0),
                           {c == 0 || c == 9, f1 || c == 10, c == 8,
                            f1 ? pa[0] : (c == 10), f1 & wb[0]});
    end
    @(posedge CLOCK); #1 drive(0, 1'b0, '0, '0);

    run_rand(8, 8, 2, 300);
    run_rand(0, 8, 0, 300);
    run_rand(2, 2, 1, 300);
    run_rand(32, 32, 3, 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
